// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyph codes, glyph width
// and the all-dark segment pattern.
package seg_pkg;

    localparam int GLYPH_W = 5;

    typedef logic [GLYPH_W-1:0] glyph_t;

    // Codes 0..15 are the hex digits; the named codes below follow them.
    localparam glyph_t GLYPH_BLANK = 5'd16;
    localparam glyph_t GLYPH_DASH  = 5'd17;
    localparam glyph_t GLYPH_UNDER = 5'd18;
    localparam glyph_t GLYPH_H     = 5'd19;
    localparam glyph_t GLYPH_L     = 5'd20;
    localparam glyph_t GLYPH_P     = 5'd21;
    localparam glyph_t GLYPH_R     = 5'd22;
    localparam glyph_t GLYPH_O     = 5'd23;

    // Active-low segments: all ones is a dark digit, decimal point included.
    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame handshake between the message formatter (master) and the scan
// driver (slave). Digit i owns code bits [5i+4:5i] and bit i of the masks.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    logic                          frame_valid;
    logic                          frame_ready;
    logic [GLYPH_W*NUM_DIGITS-1:0] frame_codes;
    logic [NUM_DIGITS-1:0]         frame_dp;
    logic [NUM_DIGITS-1:0]         frame_blink;
    logic [NUM_DIGITS-1:0]         frame_en;

    modport master (
        output frame_valid, frame_codes, frame_dp, frame_blink, frame_en,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, frame_codes, frame_dp, frame_blink, frame_en,
        output frame_ready
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// Glyph code to active-low segment pattern {a,b,c,d,e,f,g,dp}.
// Blank and unassigned codes produce a fully dark digit, dp included.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  glyph_t     code_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [6:0] abcdefg;
    logic       blank;

    // Look up the a..g pattern (0 = segment lit) for the requested glyph.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        abcdefg = 7'b1111111;
        blank   = 1'b0;
        case (code_i)
            5'd0:        abcdefg = 7'b0000001;
            5'd1:        abcdefg = 7'b1001111;
            5'd2:        abcdefg = 7'b0010010;
            5'd3:        abcdefg = 7'b0000110;
            5'd4:        abcdefg = 7'b1001100;
            5'd5:        abcdefg = 7'b0100100;
            5'd6:        abcdefg = 7'b0100000;
            5'd7:        abcdefg = 7'b0001111;
            5'd8:        abcdefg = 7'b0000000;
            5'd9:        abcdefg = 7'b0000100;
            5'd10:       abcdefg = 7'b0001000;
            5'd11:       abcdefg = 7'b1100000;
            5'd12:       abcdefg = 7'b0110001;
            5'd13:       abcdefg = 7'b1000010;
            5'd14:       abcdefg = 7'b0110000;
            5'd15:       abcdefg = 7'b0111000;
            GLYPH_DASH:  abcdefg = 7'b1111110;
            GLYPH_UNDER: abcdefg = 7'b1110111;
            GLYPH_H:     abcdefg = 7'b1001000;
            GLYPH_L:     abcdefg = 7'b1110001;
            GLYPH_P:     abcdefg = 7'b0011000;
            GLYPH_R:     abcdefg = 7'b1111010;
            GLYPH_O:     abcdefg = 7'b1100010;
            default:     blank   = 1'b1;
        endcase
    end

    assign seg_o = blank ? SEG_OFF : {abcdefg, ~dp_i};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver. A prescaler divides CLK into digit
// slots; each slot starts with a few dark cycles to stop ghosting, then
// strobes one enabled digit. Frames arrive through a one-deep shadow buffer
// and are promoted to the active frame only at a frame boundary, so a
// displayed frame is never torn.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int  NUM_DIGITS   = 8,
    parameter int  REFRESH_DIV  = 100000,
    parameter int  BLANK_CYCLES = 2,
    parameter int  BLINK_DIV    = 50,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    seg_scan_driver_if.slave      frame,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [7:0]            SEG,
    output logic [IDX_W-1:0]      scan_idx
);

    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CODES_W = GLYPH_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    typedef struct packed {
        logic [CODES_W-1:0]    codes;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blink;
        logic [NUM_DIGITS-1:0] en;
    } frame_t;

    localparam frame_t FRAME_BLANK = '{
        codes: {NUM_DIGITS{GLYPH_BLANK}},
        dp:    '0,
        blink: '0,
        en:    '0
    };

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_t                act_q, act_d;
    frame_t                sh_q, sh_d;
    logic                  sh_full_q, sh_full_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    frame_t                in_frame;
    logic                  slot_tick;
    logic                  wrap_tick;
    logic                  accept;
    logic                  swap;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      hi_idx;
    logic [IDX_W-1:0]      lo_idx;
    logic                  found_hi;
    logic                  found_lo;
    glyph_t                cur_code;
    logic [7:0]            glyph_seg;

    assign in_frame = '{
        codes: frame.frame_codes,
        dp:    frame.frame_dp,
        blink: frame.frame_blink,
        en:    frame.frame_en
    };

    assign slot_tick         = (cnt_q == CNT_LAST);
    assign accept            = frame.frame_valid && !sh_full_q;
    assign frame.frame_ready = !sh_full_q;

    // Find the next enabled digit above the current one, else the lowest enabled one, else stay.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (act_q.en[j] && !found_lo) begin
                lo_idx   = IDX_W'(j);
                found_lo = 1'b1;
            end
            if (act_q.en[j] && !found_hi && (IDX_W'(j) > idx_q)) begin
                hi_idx   = IDX_W'(j);
                found_hi = 1'b1;
            end
        end
        next_idx = found_hi ? hi_idx : (found_lo ? lo_idx : idx_q);
    end

    // A slot tick that does not move the pointer upward closes a scan frame.
    assign wrap_tick = slot_tick && (next_idx <= idx_q);
    assign swap      = wrap_tick && sh_full_q;

    // Next state: prescaler, scan pointer, buffer promotion and blink phase.
    always_comb begin
        cnt_d     = slot_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_tick ? next_idx : idx_q;
        act_d     = swap ? sh_q : act_q;
        sh_d      = accept ? in_frame : sh_q;
        sh_full_d = sh_full_q;
        if (accept) begin
            sh_full_d = 1'b1;
        end else if (swap) begin
            sh_full_d = 1'b0;
        end
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (wrap_tick) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = !phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    // The pins are registered from next-state values, so a new slot (and a
    // freshly promoted frame) shows up on the cycle right after the tick.
    assign cur_code = act_d.codes[GLYPH_W*int'(idx_d) +: GLYPH_W];

    seg_glyph_decode u_decode (
        .code_i (cur_code),
        .dp_i   (act_d.dp[idx_d]),
        .seg_o  (glyph_seg)
    );

    // Pin drive: dark during anti-ghost cycles or for a disabled digit; a blinking digit keeps its anode strobe.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (act_d.en[idx_d] && (cnt_d >= BLANK_END)) begin
            an_d[idx_d] = 1'b0;
            if (!(phase_d && act_d.blink[idx_d])) begin
                seg_d = glyph_seg;
            end
        end
    end

    // Control state and pin registers; reset returns to a dark display with an empty shadow.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the values from before the edge.
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            act_q     <= FRAME_BLANK;
            sh_full_q <= 1'b0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            sh_full_q <= sh_full_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    // Shadow payload capture.
    // NOTE: the payload is only read while sh_full_q is set, so only the flag needs a reset.
    always_ff @(posedge CLK) begin
        sh_q <= sh_d;
    end

    assign AN       = an_q;
    assign SEG      = seg_q;
    assign scan_idx = idx_q;

endmodule
